// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// Build option: DMEM_MISALIGN_TRAP_EN (see dmem_access_ctrl.sv).
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords must sit on an even byte, everything wider on a word boundary.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      default:     bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store byte enables / replicated write data,
// and load lane selection with sign or zero extension.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    be         = 4'b0000;
    lane_wdata = 32'h0;
    case (st_funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << st_off;
        lane_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << {st_off[1], 1'b0};
        lane_wdata = {2{st_data[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (ld_off)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
  end

  always_comb begin
    ld_data = ld_raw;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store controller driving a req/ack data-memory port.
// Build option: define DMEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              mem_start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              mem_ready,
  output logic [31:0]       rdata,
  output logic              bus_err,
  output logic              misaligned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack
);

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int                CNT_W    = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  dmem_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_off;
  logic             misaligned_q;

  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;
  logic [31:0]      ld_ext;
  logic             op_valid;
  logic             op_we;

  // Both read and write high is illegal and handled as a load.
  assign op_valid   = mem_read | mem_write;
  assign op_we      = mem_write & ~mem_read;
  assign misaligned = misaligned_q;

  dmem_lane_align u_lane (
    .st_funct3  (funct3),
    .st_off     (addr[1:0]),
    .st_data    (wdata),
    .be         (be_nxt),
    .lane_wdata (wdata_nxt),
    .ld_funct3  (ld_funct3),
    .ld_off     (ld_off),
    .ld_raw     (dmem_rdata),
    .ld_data    (ld_ext)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state        <= IDLE;
      cnt          <= '0;
      ld_funct3    <= F3_W;
      ld_off       <= 2'b00;
      mem_ready    <= 1'b1;
      rdata        <= 32'h0;
      bus_err      <= 1'b0;
      misaligned_q <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= 4'b0000;
      dmem_wdata   <= 32'h0;
    end else begin
      bus_err      <= 1'b0;
      misaligned_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_start && op_valid) begin
            mem_ready <= 1'b0;
            if (TRAP_EN && is_misaligned(funct3, addr[1:0])) begin
              state        <= ERR;
              misaligned_q <= 1'b1;
              rdata        <= 32'h0;
            end else begin
              state      <= REQ;
              cnt        <= '0;
              ld_funct3  <= funct3;
              ld_off     <= addr[1:0];
              dmem_req   <= 1'b1;
              dmem_we    <= op_we;
              dmem_addr  <= addr[ADDR_W+1:2];
              dmem_be    <= be_nxt;
              dmem_wdata <= wdata_nxt;
            end
          end
        end
        REQ: begin
          // An ack arriving on the limit cycle still completes normally.
          if (dmem_ack) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            mem_ready <= 1'b1;
            if (!dmem_we) rdata <= ld_ext;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            mem_ready <= 1'b1;
            bus_err   <= 1'b1;
            rdata     <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          state     <= IDLE;
          mem_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          mem_ready <= 1'b1;
          dmem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, scoreboard-based bench for dmem_access_ctrl (default build, TIMEOUT=4).
module tb_dmem_access_ctrl;

  localparam int ADDR_W = 30;
  localparam int TMO    = 4;

  logic              clk = 1'b0;
  logic              rstN;
  logic              mem_start, mem_read, mem_write;
  logic [2:0]        funct3;
  logic [31:0]       addr, wdata;
  logic              mem_ready;
  logic [31:0]       rdata;
  logic              bus_err, misaligned;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .mem_start  (mem_start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .mem_ready  (mem_ready),
    .rdata      (rdata),
    .bus_err    (bus_err),
    .misaligned (misaligned),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        bus_err;
    int          low;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access starting just after a rising edge. ack_at is the REQ cycle
  // index (0 = first) on which dmem_ack is raised; negative means never.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] raw, input int ack_at,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    exp_t e;
    exp_t got;
    int   low;
    int   reqc;
    bit   done;
    e.rdata   = exp_rdata;
    e.bus_err = (ack_at < 0);
    e.low     = (ack_at < 0) ? TMO : ack_at + 1;
    mem_start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    mem_start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    check({tag, "_be"},    32'(dmem_be), 32'(exp_be));
    check({tag, "_addr"},  32'(dmem_addr), {2'b00, a[31:2]});
    check({tag, "_wdata"}, dmem_wdata, exp_wd);
    check({tag, "_we"},    32'(dmem_we), 32'(wr & ~rd));
    low = 0; reqc = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (mem_ready) begin
        done = 1'b1;
      end else begin
        low++;
        if (dmem_req) reqc++;
        dmem_ack   = (c == ack_at);
        dmem_rdata = (c == ack_at) ? raw : 32'h5A5A5A5A;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    got = exp_q.pop_front();
    check({tag, "_rdata"},    rdata, got.rdata);
    check({tag, "_bus_err"},  32'(bus_err), 32'(got.bus_err));
    check({tag, "_low"},      32'(low), 32'(got.low));
    check({tag, "_req_cyc"},  32'(reqc), 32'(got.low));
    check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    check({tag, "_misal"},    32'(misaligned), 32'd0);
    @(posedge clk); #1;
    check({tag, "_err_pulse"}, 32'(bus_err), 32'd0);
    check({tag, "_idle"},      32'(mem_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; mem_start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(mem_ready), 32'd1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_berr",  32'(bus_err), 32'd0);
    check("rst_misal", 32'(misaligned), 32'd0);
    check("rst_req",   32'(dmem_req), 32'd0);
    check("rst_we",    32'(dmem_we), 32'd0);
    check("rst_addr",  32'(dmem_addr), 32'h0);
    check("rst_be",    32'(dmem_be), 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    rstN = 1'b1;
    @(posedge clk); #1;

    access("sw",     1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 32'h00000000, 4'b1111, 32'hDEADBEEF);
    access("lb",     1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80000000, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
    access("lbu",    1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80000000, 1, 32'h00000080, 4'b1000, 32'h0);
    access("sh",     1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        0, 32'h00000080, 4'b1100, 32'h12341234);
    access("lh",     1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 2, 32'hFFFF8001, 4'b1100, 32'h0);
    access("lhu",    1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h1234ABCD, 1, 32'h0000ABCD, 4'b0011, 32'h0);
    access("sb",     1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 32'h0000ABCD, 4'b0010, 32'hA5A5A5A5);
    access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, 4'b1111, 32'h0);
    access("rw_ld",  1'b1, 1'b1, 3'b010, 32'h104, 32'h0,        32'h0BADF00D, 0, 32'h0BADF00D, 4'b1111, 32'h0);
    access("tmo",    1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        32'h0,       -1, 32'h00000000, 4'b1111, 32'h0);
    access("ack_lim",1'b1, 1'b0, 3'b010, 32'h204, 32'h0,        32'h11223344, 3, 32'h11223344, 4'b1111, 32'h0);

    // Start with neither read nor write must not launch an access.
    mem_start = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    mem_start = 1'b0;
    check("nop_ready", 32'(mem_ready), 32'd1);
    check("nop_req",   32'(dmem_req), 32'd0);

    // Reset while a request is outstanding, then a late ack.
    mem_start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    mem_start = 1'b0; mem_read = 1'b0;
    check("mid_req_on", 32'(dmem_req), 32'd1);
    rstN = 1'b0;
    @(posedge clk); #1;
    check("mid_req_off", 32'(dmem_req), 32'd0);
    check("mid_ready",   32'(mem_ready), 32'd1);
    rstN = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ready", 32'(mem_ready), 32'd1);
    check("late_rdata", rdata, 32'h0);
    check("late_req",   32'(dmem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
